// File: rtl/digit_serial_addsub.sv
// ============================================================================
// Module   : digit_serial_addsub (+ adder_subtractor4_rc slice)
// Brief    : NIBBLES*4-bit add/subtract computed one nibble per clock through
//            a single 4-bit ripple-carry add/sub slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_subtractor4_rc (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic       sub,
    output logic [3:0] g,
    output logic       co
);
    logic [3:0] w_bx;
    logic [4:0] w_c;

    always_comb begin
        w_bx   = b ^ {4{sub}};
        w_c    = 5'd0;
        w_c[0] = ci;
        g      = 4'd0;
        for (int i = 0; i < 4; i++) begin
            g[i]     = a[i] ^ w_bx[i] ^ w_c[i];
            w_c[i+1] = (a[i] & w_bx[i]) | (w_c[i] & (a[i] ^ w_bx[i]));
        end
        co = w_c[4];
    end
endmodule

module digit_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   x,
    input  logic [4*NIBBLES-1:0]   y,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry_out,
    output logic                   overflow
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NIBBLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  x_sh_q, x_sh_d;
    logic [W-1:0]  y_sh_q, y_sh_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          op_q, op_d;
    logic          carry_q, carry_d;
    logic          xs_q, xs_d;
    logic          ys_q, ys_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [W-1:0]  result_q, result_d;
    logic          carry_out_q, carry_out_d;
    logic          overflow_q, overflow_d;

    logic [3:0]    w_g;
    logic          w_co;
    logic [W+3:0]  w_cat;
    logic          w_ovf;

    adder_subtractor4_rc u_slice (
        .a   (x_sh_q[3:0]),
        .b   (y_sh_q[3:0]),
        .ci  (carry_q),
        .sub (op_q),
        .g   (w_g),
        .co  (w_co)
    );

    // Concatenate then shift so the NIBBLES=1 case needs no empty slice.
    assign w_cat = {w_g, acc_q} >> 4;
    assign w_ovf = op_q ? ((xs_q != ys_q) && (w_g[3] != xs_q))
                        : ((xs_q == ys_q) && (w_g[3] != xs_q));

    always_comb begin
        state_d     = state_q;
        x_sh_d      = x_sh_q;
        y_sh_d      = y_sh_q;
        acc_d       = acc_q;
        op_d        = op_q;
        carry_d     = carry_q;
        xs_d        = xs_q;
        ys_d        = ys_q;
        idx_d       = idx_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    x_sh_d  = x;
                    y_sh_d  = y;
                    op_d    = op;
                    xs_d    = x[W-1];
                    ys_d    = y[W-1];
                    carry_d = op;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = w_cat[W-1:0];
                carry_d = w_co;
                x_sh_d  = x_sh_q >> 4;
                y_sh_d  = y_sh_q >> 4;
                idx_d   = idx_q + 1'b1;
                if (idx_q == C_LAST) begin
                    result_d    = w_cat[W-1:0];
                    carry_out_d = w_co;
                    overflow_d  = w_ovf;
                    state_d     = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_sh_q      <= '0;
            y_sh_q      <= '0;
            acc_q       <= '0;
            op_q        <= 1'b0;
            carry_q     <= 1'b0;
            xs_q        <= 1'b0;
            ys_q        <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_sh_q      <= x_sh_d;
            y_sh_q      <= y_sh_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            xs_q        <= xs_d;
            ys_q        <= ys_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
// ============================================================================
// Module   : tb_digit_serial_addsub
// Brief    : directed + randomized bench with a cycle-level arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_digit_serial_addsub;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] result;

    int errors = 0;
    int checks = 0;

    digit_serial_addsub #(.NIBBLES(NIB)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .x(x), .y(y),
        .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request finishes NIB edges later with plain arithmetic.
    logic         m_busy, m_done, m_co, m_ov;
    logic [W-1:0] m_res;
    int           m_left;
    logic [W-1:0] p_res;
    logic         p_co, p_ov;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0; m_co <= 1'b0;
            m_ov <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    longint sx, sy, s;
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    s  = op ? sx - sy : sx + sy;
                    p_res  <= op ? W'(x - y) : W'(x + y);
                    p_co   <= op ? (x >= y) : ((longint'(x) + longint'(y)) >= (longint'(1) << W));
                    p_ov   <= (s > ((longint'(1) << (W-1)) - 1)) || (s < -(longint'(1) << (W-1)));
                    m_busy <= 1'b1;
                    m_left <= NIB;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1;
                    m_res <= p_res; m_co <= p_co; m_ov <= p_ov;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("result", result, m_res);
        chk("carry_out", carry_out, m_co);
        chk("overflow", overflow, m_ov);
    end

    // Caller sits at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                          input logic [W-1:0] er, input logic eco, input logic eov);
        int n, nb;
        start = 1'b1; op = o; x = a; y = b;
        @(negedge clk);
        start = 1'b0; x = $urandom; y = $urandom; op = $urandom;
        n = 1; nb = busy ? 1 : 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end
        chk("lat_negedges", n, NIB + 1);
        chk("busy_cycles", nb, NIB);
        chk("lit_result", result, er);
        chk("lit_co", carry_out, eco);
        chk("lit_ov", overflow, eov);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        @(negedge clk);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        @(negedge clk);
        run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        @(negedge clk);
        run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        @(negedge clk);

        // Start requested while busy must be ignored.
        start = 1'b1; op = 1'b0; x = 16'h0100; y = 16'h0200;
        @(negedge clk);
        op = 1'b1; x = 16'hAAAA; y = 16'h5555;
        @(negedge clk);
        start = 1'b0; x = 16'h1111; y = 16'h2222;
        repeat (6) @(negedge clk);
        chk("ignored_start_result", result, 16'h0300);
        chk("ignored_start_idle", busy, 0);

        // Asynchronous reset mid-RUN.
        run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 1'b0; x = 16'h4444; y = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_result", result, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_co", carry_out, 0);
        chk("arst_ov", overflow, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        @(negedge clk);

        // Back-to-back: accept in the DONE cycle.
        run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op(16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1, 1'b0);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            op    = $urandom;
            x     = $urandom;
            y     = $urandom;
        end
        start = 1'b0;
        repeat (NIB + 3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

`default_nettype wire
